// File: rtl/banked_bus_ram_if.sv
// Bus bundle between the CPU data-bus master and the banked RAM slave.
interface banked_bus_ram_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              rd;
   logic              wr;
   logic [DATA_W-1:0] rdata;
   logic              data_oe;
   logic              ready;
   logic              busy;

   modport master (output addr, wdata, rd, wr, input rdata, data_oe, ready, busy);
   modport slave  (input addr, wdata, rd, wr, output rdata, data_oe, ready, busy);
endinterface

// File: rtl/banked_bus_ram.sv
// Clocked bank-switched RAM slave: fixed bank 0 in the lower window half, selectable bank above.
// Optional power-up clear sweep enabled by defining BANKED_BUS_RAM_CLEAR_EN.
module banked_bus_ram #(
   parameter int unsigned       ADDR_W        = 16,
   parameter int unsigned       DATA_W        = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'hC000,
   parameter int unsigned       WIN_BITS      = 13,
   parameter int unsigned       BANK_BITS     = 3,
   parameter logic [ADDR_W-1:0] BANK_REG_ADDR = 16'hFF70,
   parameter int unsigned       READ_WAIT     = 1
) (
   input logic               clk,
   input logic               reset_n,
   banked_bus_ram_if.slave   bus
);
   localparam int unsigned       OFF_W    = WIN_BITS - 1;
   localparam int unsigned       IDX_W    = OFF_W + BANK_BITS;
   localparam int unsigned       DEPTH    = 1 << IDX_W;
   localparam int unsigned       CNT_W    = 4;
   localparam logic [ADDR_W-1:0] WIN_MASK = ~ADDR_W'((1 << WIN_BITS) - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_CLEAR} state_t;

`ifdef BANKED_BUS_RAM_CLEAR_EN
   localparam state_t RST_STATE = S_CLEAR;
`else
   localparam state_t RST_STATE = S_IDLE;
`endif

   state_t               state_q, state_nxt;
   logic [BANK_BITS-1:0] bank_q, bank_nxt;
   logic [IDX_W-1:0]     idx_q, idx_nxt;
   logic                 reg_q, reg_nxt;
   logic [ADDR_W-1:0]    addr_q, addr_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;
   logic [DATA_W-1:0]    rdata_q, rdata_nxt;
   logic                 ready_q, ready_nxt;
   logic                 oe_q, oe_nxt;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic                 mem_we;
   logic [IDX_W-1:0]     mem_waddr;
   logic [DATA_W-1:0]    mem_wdata;

   logic                 hit_win, hit_reg, req;
   logic [BANK_BITS-1:0] eff_bank;
   logic [IDX_W-1:0]     idx;
   logic                 rd_fin;
   logic [IDX_W-1:0]     src_idx;
   logic                 src_reg;

`ifdef BANKED_BUS_RAM_CLEAR_EN
   logic [IDX_W-1:0]     clr_q, clr_nxt;
   logic                 busy_q;
`endif

   // Address decode and RAM index for the live bus address
   always_comb begin
      hit_win  = (bus.addr & WIN_MASK) == BASE_ADDR;
      hit_reg  = bus.addr == BANK_REG_ADDR;
      req      = (bus.rd | bus.wr) & (hit_win | hit_reg);
      eff_bank = '0;
      if (bus.addr[WIN_BITS-1])
         eff_bank = (bank_q == '0) ? BANK_BITS'(1) : bank_q;
      idx      = {eff_bank, bus.addr[OFF_W-1:0]};
   end

   // Next-state, latched transfer context and memory write port
   always_comb begin
      state_nxt = state_q;
      bank_nxt  = bank_q;
      idx_nxt   = idx_q;
      reg_nxt   = reg_q;
      addr_nxt  = addr_q;
      cnt_nxt   = cnt_q;
      rd_fin    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = idx;
      mem_wdata = bus.wdata;
`ifdef BANKED_BUS_RAM_CLEAR_EN
      clr_nxt   = clr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               idx_nxt  = idx;
               reg_nxt  = hit_reg;
               addr_nxt = bus.addr;
               if (bus.wr) begin
                  state_nxt = S_DONE;
                  if (hit_reg) bank_nxt = bus.wdata[BANK_BITS-1:0];
                  else         mem_we   = 1'b1;
               end else if (READ_WAIT == 0) begin
                  state_nxt = S_DONE;
                  rd_fin    = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = CNT_W'(READ_WAIT - 1);
               end
            end
         end
         S_WAIT: begin
            // A master that gives up or moves mid-wait loses the transfer silently
            if (!bus.rd || bus.wr || bus.addr != addr_q) begin
               state_nxt = S_IDLE;
            end else if (cnt_q == '0) begin
               state_nxt = S_DONE;
               rd_fin    = 1'b1;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: state_nxt = S_IDLE;
`ifdef BANKED_BUS_RAM_CLEAR_EN
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
            mem_wdata = '0;
            if (clr_q == IDX_W'(DEPTH - 1)) state_nxt = S_IDLE;
            else                            clr_nxt   = clr_q + IDX_W'(1);
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Read data source: live decode on a zero-wait read, latched context otherwise
   always_comb begin
      src_idx   = (state_q == S_IDLE) ? idx : idx_q;
      src_reg   = (state_q == S_IDLE) ? hit_reg : reg_q;
      ready_nxt = state_nxt == S_DONE;
      oe_nxt    = rd_fin;
      rdata_nxt = '0;
      if (rd_fin)
         rdata_nxt = src_reg ? {{(DATA_W-BANK_BITS){1'b1}}, bank_q} : mem[src_idx];
   end

   always_ff @(posedge clk) begin
      if (mem_we && reset_n) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RST_STATE;
         bank_q  <= '0;
         idx_q   <= '0;
         reg_q   <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         bank_q  <= bank_nxt;
         idx_q   <= idx_nxt;
         reg_q   <= reg_nxt;
         addr_q  <= addr_nxt;
         cnt_q   <= cnt_nxt;
         rdata_q <= rdata_nxt;
         ready_q <= ready_nxt;
         oe_q    <= oe_nxt;
      end
   end

`ifdef BANKED_BUS_RAM_CLEAR_EN
   // Busy comes up with reset release and stays high for the whole sweep
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_q  <= '0;
         busy_q <= 1'b1;
      end else begin
         clr_q  <= clr_nxt;
         busy_q <= state_nxt == S_CLEAR;
      end
   end
   assign bus.busy = busy_q;
`else
   assign bus.busy = 1'b0;
`endif

   assign bus.rdata   = rdata_q;
   assign bus.data_oe = oe_q;
   assign bus.ready   = ready_q;
endmodule
